// File: rtl/pc_return_stack.sv
// Circular return-address stack for the program counter: CALL/interrupt push,
// RETURN/RETLW/RETFIE pop, with saturating depth count, sticky error flags and a peek port.
module pc_return_stack #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_flags,
  input  logic [PTR_W-1:0] peek_idx,
  output logic [WIDTH-1:0] peek_data
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] peek_addr;
  logic             ovf_set;
  logic             udf_set;

  always_comb begin
    top_idx   = ptr - PTR_W'(1);
    peek_addr = top_idx - peek_idx;
    out       = mem[top_idx];
    peek_data = mem[peek_addr];
    full      = (count == DEPTH_C);
    empty     = (count == '0);
    // A replace (push+pop) never overflows; any pop on empty underflows.
    ovf_set   = push & ~pop & full;
    udf_set   = pop & empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case ({push, pop})
        2'b10: begin
          mem[ptr] <= in;
          ptr      <= ptr + PTR_W'(1);
          if (!full) count <= count + (PTR_W + 1)'(1);
        end
        2'b01: begin
          ptr <= ptr - PTR_W'(1);
          if (!empty) count <= count - (PTR_W + 1)'(1);
        end
        2'b11: begin
          mem[top_idx] <= in;
          if (empty) count <= (PTR_W + 1)'(1);
        end
        default: ;
      endcase
      overflow  <= ovf_set | (overflow & ~clr_flags);
      underflow <= udf_set | (underflow & ~clr_flags);
    end
  end

endmodule

// File: doc/pc_return_stack.md
Name: pc_return_stack

Overview:
- Return-address stack that sits on the other end of the program counter's push/pop interface.
- Stores return addresses on CALL and on interrupt entry; supplies them on RETURN/RETLW/RETFIE.
- Models PIC16F-style circular behaviour: a push past full overwrites the oldest entry, and a pop from empty wraps.
- Adds a saturating depth count, sticky overflow/underflow flags for the debugger/testbench, and a non-destructive peek port.

Parameters:
- WIDTH, 13, address width of each entry; matches the program counter width.
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- PTR_W, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  write `in` to the slot above the current top.
- pop  input  1  discard the current top.
- in  input  WIDTH  address to push; sampled on the edge where push=1.
- out  output  WIDTH  current top of stack, combinational from stored state.
- count  output  PTR_W+1  number of valid entries, saturating in 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky flag: a push occurred while full.
- underflow  output  1  sticky flag: a pop occurred while empty.
- clr_flags  input  1  clears overflow and underflow.
- peek_idx  input  PTR_W  entry index relative to top; 0 = top.
- peek_data  output  WIDTH  value of mem[ptr-1-peek_idx], mod DEPTH, combinational.

Behaviour:

Storage and pointer
- Storage is mem[0..DEPTH-1] plus a write pointer `ptr` (PTR_W bits, wraps mod DEPTH).
- out = mem[ptr-1 mod DEPTH], purely combinational.
- The program counter loads out in the same edge that pop is asserted, so no registered read latency is allowed.

Reset
- rst=1 at a clock edge: ptr=0, count=0, all mem entries=0, overflow=0, underflow=0.
- After reset: out=0, peek_data=0, empty=1, full=0.
- Reset has priority over push, pop and clr_flags in the same cycle.

Push only (push=1, pop=0)
- mem[ptr] <= in; ptr <= ptr+1.
- If count<DEPTH, count increments.
- If count==DEPTH, count stays at DEPTH, overflow <= 1, and the oldest entry is silently overwritten (circular).
- out reflects the new value from the next cycle.

Pop only (push=0, pop=1)
- ptr <= ptr-1; mem is unchanged.
- If count>0, count decrements.
- If count==0, count stays 0, underflow <= 1, and the pointer still wraps. The subsequent out is whatever stale value sits in that slot; there is no error response.

Push and pop together
- Defined as pop followed by push, i.e. replace the top.
- mem[ptr-1] <= in; ptr is unchanged.
- out in that cycle still shows the old top.
- If count==0: underflow <= 1 and count <= 1. Otherwise count is unchanged.
- overflow is never set by a simultaneous push and pop.

Neither push nor pop
- All state holds.

Flags
- clr_flags=1 clears overflow and underflow at the edge.
- If clr_flags and a setting event occur in the same cycle, the set wins (the flag reads 1 afterwards).

Latency and widths
- All updates take effect one edge after the request.
- There are no stalls and no busy state; a push or pop is accepted every cycle.
- Pointer arithmetic is modulo DEPTH.
- count arithmetic is saturating and never wraps.
- in and out are full WIDTH; no truncation.

Test Plan:
1. Reset, then push 0x0101, 0x0202, 0x0303 on consecutive cycles -> out=0x0303, count=3, peek_idx=2 gives 0x0101; pop three times -> out sequence 0x0202, 0x0101, then 0x0000 (reset contents), empty=1, no flags set.
2. Push 9 values 0x1000..0x1008 -> full=1 after the 8th push, overflow=1 after the 9th, count=8; eight pops return 0x1008 down to 0x1001; 0x1000 is lost.
3. From reset, pop once -> underflow=1, count=0; assert clr_flags -> underflow=0; assert clr_flags and pop in the same cycle -> underflow reads 1.
4. Push 0x0AAA, then push=pop=1 with in=0x0BBB -> out=0x0AAA during that cycle, 0x0BBB after, count stays 1; same stimulus from empty -> count=1, underflow=1.
5. Push 4 values, assert rst together with push=1 -> count=0, out=0, flags clear, pushed value discarded.
6. Program-counter integration: CALL at 0x0010 then RETURN -> the PC fetches 0x0011 after the return; interrupt entry while at 0x0123 -> RETFIE resumes at 0x0123.
